// File: rtl/pcs_receive_if.sv
// SUDI input side and GMII receive side of the 1000BASE-X PCS receive function.
// Signal names follow the IEEE 802.3 clause 36 names used on the block boundary.
interface pcs_receive_if;
  logic        code_sync_status;
  logic [10:0] SUDI;
  logic [7:0]  RXD;
  logic        RX_DV;
  logic        RX_ER;
  logic        receiving;

  modport master (
    output code_sync_status, SUDI,
    input  RXD, RX_DV, RX_ER, receiving
  );

  modport slave (
    input  code_sync_status, SUDI,
    output RXD, RX_DV, RX_ER, receiving
  );
endinterface

// File: rtl/pcs_receive.sv
// 1000BASE-X PCS receive: disparity-agnostic 10b/8b decode plus packet reception FSM
// driving registered GMII RXD/RX_DV/RX_ER and the receiving flag (1 clock latency).
module pcs_receive #(
  parameter logic [7:0] SOP_BYTE = 8'h55,
  parameter logic [7:0] ERR_BYTE = 8'h0E
) (
  input logic         Clk,
  input logic         mr_main_reset,
  pcs_receive_if.slave bus
);
  localparam int unsigned GRP_W = 10;
  localparam int unsigned OCT_W = 8;

  localparam logic [GRP_W-1:0] K285_N = 10'b0011111010;
  localparam logic [GRP_W-1:0] K285_P = 10'b1100000101;
  localparam logic [GRP_W-1:0] SOP_N  = 10'b1101101000;
  localparam logic [GRP_W-1:0] SOP_P  = 10'b0010010111;
  localparam logic [GRP_W-1:0] EOP_N  = 10'b1011101000;
  localparam logic [GRP_W-1:0] EOP_P  = 10'b0100010111;
  localparam logic [GRP_W-1:0] CEX_N  = 10'b1110101000;
  localparam logic [GRP_W-1:0] CEX_P  = 10'b0001010111;

  // RD- forms (abcdei / fghj); RD+ forms are complements for unbalanced codes, D.7 and y=3.
  localparam logic [5:0] ENC6 [32] = '{
    6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
    6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
    6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
    6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011
  };
  localparam logic [3:0] ENC4 [8] = '{
    4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110
  };

  typedef enum logic [2:0] {
    LINK_FAILED,
    WAIT_FOR_K,
    RX_K,
    IDLE_D,
    RECEIVE,
    TRR_EXTEND
  } state_t;

  function automatic logic [5:0] enc6(input logic [4:0] x, input logic rd_pos);
    logic [5:0] c;
    c = ENC6[x];
    if (rd_pos && (($countones(c) != 3) || (x == 5'd7))) c = ~c;
    return c;
  endfunction

  function automatic logic [3:0] enc4(input logic [2:0] y, input logic rd_pos, input logic alt);
    logic [3:0] c;
    c = ((y == 3'd7) && alt) ? 4'b0111 : ENC4[y];
    if (rd_pos && (($countones(c) != 2) || (y == 3'd3))) c = ~c;
    return c;
  endfunction

  // Full 10b encoding of an octet starting from the given running disparity.
  function automatic logic [GRP_W-1:0] enc10(input logic [OCT_W-1:0] d, input logic rd_pos);
    logic [5:0] c6;
    logic       rd_mid;
    logic       alt;
    c6     = enc6(d[4:0], rd_pos);
    rd_mid = rd_pos ^ ($countones(c6) != 3);
    alt    = rd_mid ? ((d[4:0] == 5'd11) || (d[4:0] == 5'd13) || (d[4:0] == 5'd14))
                    : ((d[4:0] == 5'd17) || (d[4:0] == 5'd18) || (d[4:0] == 5'd20));
    return {c6, enc4(d[7:5], rd_mid, alt)};
  endfunction

  // Returns {valid, octet}: sub-blocks are located independently, then the whole
  // group must equal the octet's RD- or RD+ encoding.
  function automatic logic [OCT_W:0] dec10(input logic [GRP_W-1:0] g);
    logic [4:0] x;
    logic [2:0] y;
    logic       f6;
    logic       f4;
    logic       ok;
    x  = '0;
    y  = '0;
    f6 = 1'b0;
    f4 = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if ((enc6(5'(i), 1'b0) == g[9:4]) || (enc6(5'(i), 1'b1) == g[9:4])) begin
        x  = 5'(i);
        f6 = 1'b1;
      end
    end
    for (int j = 0; j < 8; j++) begin
      for (int a = 0; a < 2; a++) begin
        if ((enc4(3'(j), 1'b0, 1'(a)) == g[3:0]) || (enc4(3'(j), 1'b1, 1'(a)) == g[3:0])) begin
          y  = 3'(j);
          f4 = 1'b1;
        end
      end
    end
    ok = f6 && f4 && ((g == enc10({y, x}, 1'b0)) || (g == enc10({y, x}, 1'b1)));
    return {ok, y, x};
  endfunction

  state_t           r_state;
  state_t           w_state_nxt;
  logic [OCT_W-1:0] r_rxd;
  logic [OCT_W-1:0] w_rxd_nxt;
  logic             r_rx_dv;
  logic             w_rx_dv_nxt;
  logic             r_rx_er;
  logic             w_rx_er_nxt;
  logic             r_receiving;
  logic             w_receiving_nxt;

  logic [GRP_W-1:0] w_grp;
  logic             w_even;
  logic [OCT_W:0]   w_dec;
  logic             w_is_data;
  logic             w_is_k;
  logic             w_is_s;
  logic             w_is_t;
  logic             w_is_r;

  assign w_grp     = bus.SUDI[9:0];
  assign w_even    = bus.SUDI[10];
  assign w_dec     = dec10(w_grp);
  assign w_is_data = w_dec[OCT_W];
  assign w_is_k    = (w_grp == K285_N) || (w_grp == K285_P);
  assign w_is_s    = (w_grp == SOP_N)  || (w_grp == SOP_P);
  assign w_is_t    = (w_grp == EOP_N)  || (w_grp == EOP_P);
  assign w_is_r    = (w_grp == CEX_N)  || (w_grp == CEX_P);

  // Next state and next registered outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_rxd_nxt   = '0;
    w_rx_dv_nxt = 1'b0;
    w_rx_er_nxt = 1'b0;
    if (!bus.code_sync_status) begin
      w_state_nxt = LINK_FAILED;
      if (r_receiving) begin
        w_rx_er_nxt = 1'b1;
        w_rxd_nxt   = ERR_BYTE;
      end
    end else begin
      case (r_state)
        LINK_FAILED: w_state_nxt = WAIT_FOR_K;
        WAIT_FOR_K:  if (w_is_k && w_even) w_state_nxt = RX_K;
        RX_K:        w_state_nxt = w_is_data ? IDLE_D : WAIT_FOR_K;
        IDLE_D: begin
          if (w_is_k) begin
            w_state_nxt = RX_K;
          end else if (w_is_s) begin
            w_state_nxt = RECEIVE;
            w_rx_dv_nxt = 1'b1;
            w_rxd_nxt   = SOP_BYTE;
          end else begin
            w_state_nxt = WAIT_FOR_K;
          end
        end
        RECEIVE: begin
          if (w_is_data) begin
            w_rx_dv_nxt = 1'b1;
            w_rxd_nxt   = w_dec[OCT_W-1:0];
          end else if (w_is_t) begin
            w_state_nxt = TRR_EXTEND;
          end else if (w_is_k && w_even) begin
            w_state_nxt = RX_K;
            w_rx_er_nxt = 1'b1;
            w_rxd_nxt   = ERR_BYTE;
          end else begin
            w_rx_dv_nxt = 1'b1;
            w_rx_er_nxt = 1'b1;
            w_rxd_nxt   = ERR_BYTE;
          end
        end
        TRR_EXTEND: begin
          if (w_is_r)      w_state_nxt = TRR_EXTEND;
          else if (w_is_k) w_state_nxt = RX_K;
          else             w_state_nxt = WAIT_FOR_K;
        end
        default: w_state_nxt = LINK_FAILED;
      endcase
    end
    w_receiving_nxt = (w_state_nxt == RECEIVE) || (w_state_nxt == TRR_EXTEND);
  end

  always_ff @(posedge Clk) begin
    if (mr_main_reset) begin
      r_state     <= LINK_FAILED;
      r_rxd       <= '0;
      r_rx_dv     <= 1'b0;
      r_rx_er     <= 1'b0;
      r_receiving <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_rxd       <= w_rxd_nxt;
      r_rx_dv     <= w_rx_dv_nxt;
      r_rx_er     <= w_rx_er_nxt;
      r_receiving <= w_receiving_nxt;
    end
  end

  assign bus.RXD       = r_rxd;
  assign bus.RX_DV     = r_rx_dv;
  assign bus.RX_ER     = r_rx_er;
  assign bus.receiving = r_receiving;
endmodule

// File: doc/pcs_receive.md
Name: pcs_receive

Overview:
- 1000BASE-X PCS receive function; the far end of the transmitter → synchronizer loopback.
- Consumes SUDI (code group plus rx_even) from the synchronizer and code_sync_status.
- Decodes 10b code groups to 8b and runs the packet-reception state machine.
- Drives the GMII receive side: RXD, RX_DV, RX_ER, plus the receiving flag.

Parameters:
- SOP_BYTE, 8'h55: value placed on RXD for the cycle that replaces /S/.
- ERR_BYTE, 8'h0E: value placed on RXD whenever RX_ER=1 with RX_DV=1.

Ports:
- Clk  input  1  system clock; all state changes on the rising edge.
- mr_main_reset  input  1  synchronous, active-high reset.
- code_sync_status  input  1  1 = synchronizer locked.
- SUDI  input  11  [10] rx_even; [9:0] code group, bit 9 = 'a' … bit 0 = 'j' (abcdei_fghj).
- RXD  output  8  decoded octet.
- RX_DV  output  1  receive data valid.
- RX_ER  output  1  receive error.
- receiving  output  1  1 while inside a packet (RECEIVE or TRR_EXTEND).

Behaviour:
- One clock, Clk. Reset is synchronous and active-high (mr_main_reset).
- Reset values: RXD=8'h00, RX_DV=0, RX_ER=0, receiving=0, state=LINK_FAILED. Reset wins over every other condition, including mid-packet.
- All outputs are registered. Latency is exactly 1 clock: outputs after edge n reflect the SUDI sampled at edge n.
- Decode is combinational and disparity-agnostic: a group matches if it equals either its RD- or RD+ encoding.
  - Data: full 5b/6b and 3b/4b tables, including D.x.7 alternate forms. Output is {HGF, EDCBA}.
  - Specials recognised: K28.5 (0011111010/1100000101), /S/ K27.7 (1101101000/0010010111), /T/ K29.7 (1011101000/0100010111), /R/ K23.7 (1110101000/0001010111).
  - Anything else is INVALID. Running-disparity errors are not checked.
- States and transitions (evaluated each edge, after reset):
  - Any state with code_sync_status=0 → LINK_FAILED. If receiving was 1, RX_ER=1 for that one cycle, RX_DV=0, RXD=ERR_BYTE.
  - LINK_FAILED: outputs 0 apart from the case above. code_sync_status=1 → WAIT_FOR_K.
  - WAIT_FOR_K: K28.5 with rx_even=1 → RX_K. K28.5 with rx_even=0 is ignored. Otherwise stay.
  - RX_K: data group → IDLE_D. Any non-data group → WAIT_FOR_K.
  - IDLE_D: K28.5 → RX_K. /S/ → RECEIVE with RX_DV=1, RXD=SOP_BYTE, receiving=1. Anything else → WAIT_FOR_K.
  - RECEIVE:
    - Data → RX_DV=1, RXD=decoded.
    - /T/ → TRR_EXTEND with RX_DV=0, RX_ER=0.
    - K28.5 with rx_even=1 (early end) → RX_K with RX_DV=0, RX_ER=1 for one cycle, receiving=0.
    - /S/, /R/, INVALID, or K28.5 with rx_even=0 → stay in RECEIVE with RX_DV=1, RX_ER=1, RXD=ERR_BYTE.
  - TRR_EXTEND: /R/ → stay, RX_DV=0. K28.5 → RX_K, receiving=0. Anything else → WAIT_FOR_K, receiving=0.
- Outside RECEIVE: RX_DV=0, RX_ER=0, RXD=8'h00, except the LINK_FAILED and early-end error cycles above.
- Back-to-back packets need at least one K28.5+D pair. /S/ seen directly in TRR_EXTEND is not a start (→ WAIT_FOR_K).

Test Plan:
1. Reset with code_sync_status=1 and idles K28.5/D16.2 (1100000101, 1001000101), rx_even alternating → RX_K/IDLE_D cycling; RX_DV=RX_ER=0; receiving=0.
2. Idles, then /S/, D12.5, D6.5 (0110011010), D21.5 (1010101010), /T/, /R/, K28.5 → one cycle after each group, RXD = 55, AC, A6, B5 with RX_DV=1; RX_DV drops on the /T/ cycle; receiving falls on the K28.5 cycle.
3. An 11-octet packet using both RD- and RD+ forms of each data group → identical RXD for both forms; no RX_ER.
4. Mid-packet group 0000000000 → exactly one cycle of RX_DV=1, RX_ER=1, RXD=0E; the following data decodes normally.
5. Mid-packet K28.5 with rx_even=1 → RX_ER=1, RX_DV=0 for one cycle, then state RX_K.
6. code_sync_status drops mid-packet → next cycle RX_ER=1, RX_DV=0, receiving=0. mr_main_reset asserted mid-packet → all outputs 0 at the next edge; reception resumes only after a fresh K28.5 (rx_even=1) / D pair.
